// File: rtl/alsu_result_buffer.sv
// Result buffer behind the ALSU reverser: a first-word-fall-through FIFO of {Sel, Zero, Parity, Data}
// entries. Writes that arrive while the FIFO is full are dropped and counted.
module alsu_result_buffer #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 4,
  parameter int DROP_CNT_W = 8
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     In_Valid,
  input  logic [WIDTH-1:0]         In_Data,
  input  logic                     In_Sel,
  input  logic                     Clr,
  input  logic                     Out_Ready,
  output logic                     Out_Valid,
  output logic [WIDTH-1:0]         Out_Data,
  output logic                     Out_Sel,
  output logic                     Out_Zero,
  output logic                     Out_Parity,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     Full,
  output logic                     Empty,
  output logic                     Overflow,
  output logic [DROP_CNT_W-1:0]    Drop_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = WIDTH + 3;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [EW-1:0]         mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic          push, pop, drop;
  logic [EW-1:0] head;

  assign pop  = !empty_q && Out_Ready && !Clr;
  assign push = In_Valid && !Clr && (!full_q || pop);
  assign drop = In_Valid && !Clr && full_q && !pop;

  // Zero and parity are computed once at write time and travel with the entry.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= {In_Sel, ~|In_Data, ^In_Data, In_Data};
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (Clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end
    full_d  = (level_d == DEPTH_L);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Head is read straight from storage and forced to zero while empty.
  assign head = mem_q[rd_ptr_q];
  assign {Out_Sel, Out_Zero, Out_Parity, Out_Data} = empty_q ? '0 : head;

  assign Out_Valid  = !empty_q;
  assign Level      = level_q;
  assign Full       = full_q;
  assign Empty      = empty_q;
  assign Overflow   = ovf_q;
  assign Drop_Count = drop_cnt_q;

endmodule

// File: tb/tb_alsu_result_buffer.sv
// Scoreboard bench for alsu_result_buffer: the driver predicts accepted entries into a queue,
// and a negedge monitor compares and pops whenever the DUT presents its head entry.
module tb_alsu_result_buffer;

  localparam int DEPTH = 4;

  logic       Clk, Rst_n;
  logic       In_Valid, In_Sel, Clr, Out_Ready;
  logic [3:0] In_Data;
  logic       Out_Valid, Out_Sel, Out_Zero, Out_Parity;
  logic [3:0] Out_Data;
  logic [2:0] Level;
  logic       Full, Empty, Overflow;
  logic [7:0] Drop_Count;

  alsu_result_buffer #(.WIDTH(4), .DEPTH(DEPTH), .DROP_CNT_W(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Data(In_Data), .In_Sel(In_Sel),
    .Clr(Clr), .Out_Ready(Out_Ready), .Out_Valid(Out_Valid), .Out_Data(Out_Data),
    .Out_Sel(Out_Sel), .Out_Zero(Out_Zero), .Out_Parity(Out_Parity), .Level(Level),
    .Full(Full), .Empty(Empty), .Overflow(Overflow), .Drop_Count(Drop_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int passed = 0;

  // Reference model: FIFO contents as a queue of {sel, zero, parity, data}.
  logic [6:0] exp_q[$];
  logic       m_ovf;
  int         m_cnt;
  logic       pend_push, pend_drop, pend_clr;
  logic [6:0] pend_entry;
  logic       mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] make_entry(input logic s, input logic [3:0] d);
    logic z, p;
    z = (d == 4'd0);
    p = ($countones(d) % 2) == 1;
    return {s, z, p, d};
  endfunction

  // Called at posedge+1: drives one cycle of inputs, predicts the edge, commits at the edge.
  task automatic cycle(input logic v, input logic [3:0] d, input logic s, input logic r, input logic c);
    int  sz;
    logic pop_p;
    In_Valid = v; In_Data = d; In_Sel = s; Out_Ready = r; Clr = c;
    sz         = exp_q.size();
    pop_p      = (sz > 0) && r && !c;
    pend_clr   = c;
    pend_push  = v && !c && ((sz < DEPTH) || pop_p);
    pend_drop  = v && !c && (sz == DEPTH) && !pop_p;
    pend_entry = make_entry(s, d);
    @(posedge Clk);
    if (pend_clr) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      if (pend_push) exp_q.push_back(pend_entry);
      if (pend_drop) begin
        m_ovf = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    pend_push = 1'b0; pend_drop = 1'b0; pend_clr = 1'b0;
    #1;
  endtask

  // Monitor: status every cycle, head entry whenever the DUT presents one.
  initial begin
    forever begin
      @(negedge Clk);
      if (mon_en) begin
        chk("level", Level, exp_q.size());
        chk("full", Full, exp_q.size() == DEPTH);
        chk("empty", Empty, exp_q.size() == 0);
        chk("overflow", Overflow, m_ovf);
        chk("drop_count", Drop_Count, m_cnt);
        chk("out_valid", Out_Valid, exp_q.size() != 0);
        if (Out_Valid) begin
          if (exp_q.size() != 0) begin
            chk("head", {Out_Sel, Out_Zero, Out_Parity, Out_Data}, exp_q[0]);
            if (Out_Ready && !Clr) void'(exp_q.pop_front());
          end
        end else begin
          chk("idle_outputs", {Out_Sel, Out_Zero, Out_Parity, Out_Data}, 7'd0);
        end
      end
    end
  end

  initial begin
    In_Valid = 0; In_Data = 0; In_Sel = 0; Clr = 0; Out_Ready = 0;
    m_ovf = 0; m_cnt = 0; pend_push = 0; pend_drop = 0; pend_clr = 0; pend_entry = 0;
    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;
    #2;
    chk("rst_valid", Out_Valid, 1'b0);
    chk("rst_empty", Empty, 1'b1);
    chk("rst_full", Full, 1'b0);
    chk("rst_level", Level, 3'd0);
    chk("rst_ovf", Overflow, 1'b0);
    chk("rst_drop", Drop_Count, 8'd0);
    chk("rst_data", {Out_Sel, Out_Zero, Out_Parity, Out_Data}, 7'd0);
    #9 Rst_n = 1'b1;
    @(posedge Clk); #1;
    mon_en = 1'b1;

    // single write, consumer ready
    cycle(1, 4'b1000, 0, 1, 0);
    cycle(0, 4'b0000, 0, 1, 0);
    cycle(0, 4'b0000, 0, 1, 0);

    // fill with consumer stalled, then two dropped writes
    cycle(1, 4'b0001, 1, 0, 0);
    cycle(1, 4'b0010, 1, 0, 0);
    cycle(1, 4'b0100, 1, 0, 0);
    cycle(1, 4'b1111, 1, 0, 0);
    cycle(1, 4'b0011, 1, 0, 0);
    cycle(1, 4'b0011, 1, 0, 0);
    chk("full_after_fill", Full, 1'b1);
    chk("drops_after_fill", Drop_Count, 8'd2);

    // full with simultaneous push and pop, then drain
    cycle(1, 4'b0110, 1, 1, 0);
    chk("level_push_pop_full", Level, 3'd4);
    chk("drops_push_pop_full", Drop_Count, 8'd2);
    repeat (5) cycle(0, 4'b0000, 0, 1, 0);

    // clear concurrent with a write, while holding entries
    cycle(1, 4'b0101, 0, 0, 0);
    cycle(1, 4'b1001, 1, 0, 0);
    cycle(1, 4'b0011, 0, 1, 1);
    chk("clr_empty", Empty, 1'b1);
    chk("clr_drop", Drop_Count, 8'd0);

    // zero result
    cycle(1, 4'b0000, 0, 1, 0);
    cycle(0, 4'b0000, 0, 1, 0);

    // pointer wrap with a ready consumer
    for (int i = 1; i <= 10; i++) cycle(1, 4'(i), i[0], 1, 0);
    cycle(0, 4'b0000, 0, 1, 0);
    chk("wrap_no_drop", Drop_Count, 8'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 7, 4'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 99) < 3);

    // async reset in the middle of a drain
    cycle(1, 4'b1100, 0, 0, 0);
    cycle(1, 4'b1010, 1, 0, 0);
    cycle(1, 4'b0111, 0, 0, 0);
    cycle(1, 4'b0111, 0, 0, 0);
    cycle(1, 4'b0111, 0, 0, 0);
    cycle(0, 4'b0000, 0, 1, 0);
    In_Valid = 0;
    #2 Rst_n = 1'b0;
    exp_q.delete(); m_ovf = 0; m_cnt = 0;
    #1;
    chk("arst_valid", Out_Valid, 1'b0);
    chk("arst_level", Level, 3'd0);
    chk("arst_ovf", Overflow, 1'b0);
    chk("arst_drop", Drop_Count, 8'd0);
    #4 Rst_n = 1'b1;
    @(posedge Clk); #1;

    cycle(1, 4'b1011, 1, 0, 0);
    cycle(1, 4'b0110, 0, 1, 0);
    repeat (3) cycle(0, 4'b0000, 0, 1, 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alsu_result_buffer.md
Name: alsu_result_buffer

Overview:
- Downstream consumer of the reverser stage in the 4-bit ALSU. Captures each reverser result (Out) and the operand-select bit (Sel) that produced it.
- Buffers results in a small FIFO, tagged with zero and parity flags, and presents them to the ALSU output interface with a valid/ready handshake.
- The reverser is combinational and cannot stall, so a write that finds the FIFO full is dropped and recorded.

Parameters:
- WIDTH, 4, data width of captured results.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DROP_CNT_W, 8, width of the dropped-write counter.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- In_Valid  input  1  a reverser result is present this cycle.
- In_Data  input  WIDTH  reverser Out.
- In_Sel  input  1  reverser Sel (0 = A reversed, 1 = B reversed).
- Clr  input  1  synchronous flush.
- Out_Ready  input  1  consumer accepts the head entry.
- Out_Valid  output  1  head entry valid.
- Out_Data  output  WIDTH  head data.
- Out_Sel  output  1  head Sel tag.
- Out_Zero  output  1  head data == 0.
- Out_Parity  output  1  XOR of the head data bits.
- Level  output  log2(DEPTH)+1  current occupancy.
- Full  output  1  Level == DEPTH.
- Empty  output  1  Level == 0.
- Overflow  output  1  sticky: at least one write was dropped.
- Drop_Count  output  DROP_CNT_W  number of dropped writes, saturating.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - Read and write pointers and Level go to 0.
  - Out_Valid = 0, Out_Data = 0, Out_Sel = 0, Out_Zero = 0, Out_Parity = 0.
  - Empty = 1, Full = 0, Overflow = 0, Drop_Count = 0.
  - Storage contents are don't-care.
- Reset mid-operation discards all entries immediately. No partial pop is visible.
- Entry format: {Sel, Zero, Parity, Data}. Zero and Parity are computed from In_Data at write time and stored with the entry.
- Push: In_Valid && !Clr && (!Full || pop this cycle).
  - Data is written at the write pointer on the rising edge.
  - The write pointer wraps from DEPTH-1 to 0.
- Pop: Out_Valid && Out_Ready && !Clr. The read pointer advances and wraps the same way.
- Output type: first-word-fall-through. Out_* are driven from the head storage entry, gated by !Empty; when Empty, Out_Data, Out_Sel, Out_Zero and Out_Parity read 0.
- Latency: a push into an empty FIFO at edge N gives Out_Valid = 1 after edge N, i.e. it is visible in cycle N+1.
- Out_* are stable while Out_Valid && !Out_Ready.
- Simultaneous push and pop:
  - Level is unchanged.
  - This is legal when Full: the write is accepted, no drop occurs.
  - This is legal when holding exactly one entry: the new entry becomes head on the next cycle.
- Push while Empty with no pop: Level goes to 1. A pop is impossible while Empty.
- Dropped write, i.e. In_Valid && Full && !pop && !Clr:
  - Data is discarded.
  - Overflow is set.
  - Drop_Count increments and saturates at 2^DROP_CNT_W-1.
- Clr (synchronous, highest priority):
  - Pointers and Level go to 0 and Out_Valid = 0 on the next cycle.
  - A concurrent In_Valid is ignored and not counted as a drop.
  - Overflow and Drop_Count are cleared.
- Level, Full and Empty are registered and consistent with the pointers every cycle.
- No combinational path from In_* to Out_*.
- Only one clock domain.

Test Plan:
- Single write with Out_Ready = 1:
  - Stimulus: In_Data = 1000 (reverser of A = 0001), In_Sel = 0.
  - Response: next cycle Out_Valid = 1, Out_Data = 1000, Out_Sel = 0, Out_Zero = 0, Out_Parity = 1. The following cycle Empty = 1.
- Fill to full with Out_Ready = 0, then overflow:
  - Stimulus: write 0001, 0010, 0100, 1111 (In_Sel = 1), then write 0011 twice.
  - Response: Full = 1, Level = 4, Overflow = 1, Drop_Count = 2.
  - Then drain with Out_Ready = 1. Response: outputs in order 0001, 0010, 0100, 1111, all with Out_Sel = 1. Parity of 1111 = 0.
- Full plus simultaneous push/pop:
  - Stimulus: FIFO full with head 0001; write 0110 with Out_Ready = 1.
  - Response: Level stays 4, no drop. After draining, 0110 appears last.
- Zero result:
  - Stimulus: write 0000.
  - Response: Out_Zero = 1, Out_Parity = 0.
- Pointer wrap-around:
  - Stimulus: 10 writes of 0001 through 1010 with Out_Ready = 1 throughout.
  - Response: outputs in the same order, Drop_Count = 0.
- Reset and Clr:
  - Stimulus: assert Rst_n = 0 mid-drain, asynchronously between edges.
  - Response: Out_Valid = 0, Level = 0 and Overflow = 0 immediately.
  - Stimulus: separately, Clr = 1 together with In_Valid.
  - Response: Empty = 1 next cycle, Drop_Count = 0.
